// File: rtl/spectrum_binner.sv
// Power binner: turns a streaming complex FFT frame into I binned |X|^2 words.
// Frames are held in a ping-pong buffer and replayed as gap-free I-cycle bursts.
module spectrum_binner #(
    parameter int BIT_WIDTH = 32,
    parameter int IN_WIDTH  = 16,
    parameter int I         = 160,
    parameter int DECIM     = 2,
    parameter int FFT_SIZE  = 1024
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic signed [IN_WIDTH-1:0] fft_re,
    input  logic signed [IN_WIDTH-1:0] fft_im,
    input  logic                       fft_in_valid,
    input  logic                       fft_in_last,
    input  logic                       downstream_ready,
    output logic                       fft_valid,
    output logic [BIT_WIDTH-1:0]       fft_data,
    output logic                       frame_dropped,
    output logic [1:0]                 frames_pending
);

    localparam int PW = 2 * IN_WIDTH + 1;
    localparam int SW = PW + $clog2(DECIM + 1);
    localparam int AW = (SW > BIT_WIDTH) ? SW : BIT_WIDTH + 1;
    localparam int NW = $clog2(FFT_SIZE + 1);
    localparam int CW = $clog2(I + 1);
    localparam int DW = $clog2(DECIM + 1);
    localparam int MW = $clog2(2 * I);

    localparam logic [NW-1:0] N_LAST   = NW'(FFT_SIZE - 1);
    localparam logic [NW-1:0] N_BINNED = NW'(I * DECIM);
    localparam logic [DW-1:0] D_LAST   = DW'(DECIM - 1);
    localparam logic [CW-1:0] B_LAST   = CW'(I - 1);

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    bank_state_t bank_q [2];
    bank_state_t bank_d [2];

    // Input side state
    logic                 sync_q;
    logic [NW-1:0]        n_q;
    logic [CW-1:0]        bin_q;
    logic [DW-1:0]        dcnt_q;
    logic [AW-1:0]        acc_q;
    logic                 filling_q;
    logic                 fill_bank_q;
    logic [CW-1:0]        wcount_q [2];
    logic                 first_full_q;

    // Drain side state
    logic                 reading_q;
    logic                 rd_bank_q;
    logic [CW-1:0]        rd_addr_q;
    logic                 v1_q;
    logic                 g1_q;
    logic [BIT_WIDTH-1:0] rd_q;

    logic [BIT_WIDTH-1:0] mem [0:2*I-1];

    logic                 accept;
    logic                 frame_start;
    logic                 close;
    logic                 any_free;
    logic                 free_pick;
    logic                 cur_bank;
    logic                 cur_ok;
    logic                 take;
    logic                 in_range;
    logic signed [PW-1:0] re_x;
    logic signed [PW-1:0] im_x;
    logic [PW-1:0]        power;
    logic [AW-1:0]        sum;
    logic                 wr_en;
    logic [BIT_WIDTH-1:0] wr_data;
    logic [MW-1:0]        wr_addr;
    logic [MW-1:0]        rd_mem_addr;
    logic                 any_full;
    logic                 any_draining;
    logic                 both_full;
    logic                 drain_go;
    logic                 drain_pick;
    logic                 drain_done;

    assign accept      = sync_q && fft_in_valid;
    assign frame_start = accept && (n_q == '0);
    assign close       = accept && (fft_in_last || (n_q == N_LAST));

    assign any_free  = (bank_q[0] == BANK_FREE) || (bank_q[1] == BANK_FREE);
    assign free_pick = (bank_q[0] != BANK_FREE);
    assign cur_bank  = frame_start ? free_pick : fill_bank_q;
    assign cur_ok    = frame_start ? any_free : filling_q;
    assign take      = accept && cur_ok;
    assign in_range  = (n_q < N_BINNED);

    assign re_x  = PW'(fft_re);
    assign im_x  = PW'(fft_im);
    assign power = $unsigned(re_x * re_x + im_x * im_x);

    // A new group starts from zero; a closing frame flushes its partial group.
    assign sum     = ((dcnt_q == '0) ? '0 : acc_q) + AW'(power);
    assign wr_en   = take && in_range && ((dcnt_q == D_LAST) || close);
    assign wr_data = (|sum[AW-1:BIT_WIDTH]) ? '1 : sum[BIT_WIDTH-1:0];
    assign wr_addr = cur_bank ? MW'(I) + MW'(bin_q) : MW'(bin_q);

    assign frame_dropped = frame_start && !any_free && !rst_in;

    assign frames_pending = 2'(bank_q[0] == BANK_FULL) + 2'(bank_q[1] == BANK_FULL);

    // Handshake: downstream_ready is looked at only on the cycle a burst starts;
    // after that fft_valid stays high for exactly I cycles with no backpressure.
    assign any_full     = (bank_q[0] == BANK_FULL) || (bank_q[1] == BANK_FULL);
    assign both_full    = (bank_q[0] == BANK_FULL) && (bank_q[1] == BANK_FULL);
    assign any_draining = (bank_q[0] == BANK_DRAINING) || (bank_q[1] == BANK_DRAINING);
    assign drain_go     = !any_draining && any_full && downstream_ready;
    assign drain_pick   = both_full ? first_full_q : (bank_q[1] == BANK_FULL);
    assign drain_done   = reading_q && (rd_addr_q == B_LAST);
    assign rd_mem_addr  = rd_bank_q ? MW'(I) + MW'(rd_addr_q) : MW'(rd_addr_q);

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            bank_d[k] = bank_q[k];
            if (take && frame_start && (cur_bank == 1'(k))) bank_d[k] = BANK_FILLING;
            if (take && close && (cur_bank == 1'(k)))       bank_d[k] = BANK_FULL;
            if (drain_go && (drain_pick == 1'(k)))          bank_d[k] = BANK_DRAINING;
            if (drain_done && (rd_bank_q == 1'(k)))         bank_d[k] = BANK_FREE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < 2; k++) bank_q[k] <= BANK_FREE;
        end else begin
            for (int k = 0; k < 2; k++) bank_q[k] <= bank_d[k];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_q       <= 1'b0;
            n_q          <= '0;
            bin_q        <= '0;
            dcnt_q       <= '0;
            acc_q        <= '0;
            filling_q    <= 1'b0;
            fill_bank_q  <= 1'b0;
            first_full_q <= 1'b0;
            for (int k = 0; k < 2; k++) wcount_q[k] <= '0;
        end else begin
            if (fft_in_valid && fft_in_last && !sync_q) sync_q <= 1'b1;

            if (accept) begin
                n_q <= close ? '0 : n_q + NW'(1);
                if (frame_start) begin
                    filling_q   <= any_free && !close;
                    fill_bank_q <= free_pick;
                end else if (close) begin
                    filling_q <= 1'b0;
                end
                if (take && in_range) begin
                    if (wr_en) begin
                        bin_q  <= bin_q + CW'(1);
                        dcnt_q <= '0;
                    end else begin
                        dcnt_q <= dcnt_q + DW'(1);
                        acc_q  <= sum;
                    end
                end
                if (close) begin
                    bin_q  <= '0;
                    dcnt_q <= '0;
                end
            end

            // Written count gates stale BRAM contents to zero on readback.
            for (int k = 0; k < 2; k++) begin
                if (wr_en && (cur_bank == 1'(k))) begin
                    wcount_q[k] <= bin_q + CW'(1);
                end else if (take && frame_start && (cur_bank == 1'(k))) begin
                    wcount_q[k] <= '0;
                end
            end

            if (take && close && (bank_q[~cur_bank] != BANK_FULL)) first_full_q <= cur_bank;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_q <= mem[rd_mem_addr];
    end

    // Two-stage read: address cycle, then BRAM output register, then output register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            reading_q <= 1'b0;
            rd_bank_q <= 1'b0;
            rd_addr_q <= '0;
            v1_q      <= 1'b0;
            g1_q      <= 1'b0;
            fft_valid <= 1'b0;
            fft_data  <= '0;
        end else begin
            if (drain_go) begin
                reading_q <= 1'b1;
                rd_bank_q <= drain_pick;
                rd_addr_q <= '0;
            end else if (reading_q) begin
                if (rd_addr_q == B_LAST) reading_q <= 1'b0;
                else                     rd_addr_q <= rd_addr_q + CW'(1);
            end
            v1_q      <= reading_q;
            g1_q      <= (rd_addr_q < wcount_q[rd_bank_q]);
            fft_valid <= v1_q;
            fft_data  <= (v1_q && g1_q) ? rd_q : '0;
        end
    end

endmodule

// File: tb/tb_spectrum_binner.sv
// Directed bench for spectrum_binner with I=4, DECIM=2, FFT_SIZE=16: vector table
// of frames with hand-computed bins, plus sync, drop, latency and reset sequences.
module tb_spectrum_binner;

    localparam int BW = 32;
    localparam int IW = 16;
    localparam int NI = 4;
    localparam int ND = 2;
    localparam int FS = 16;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic signed [IW-1:0] fft_re;
    logic signed [IW-1:0] fft_im;
    logic                 fft_in_valid;
    logic                 fft_in_last;
    logic                 downstream_ready;
    logic                 fft_valid;
    logic [BW-1:0]        fft_data;
    logic                 frame_dropped;
    logic [1:0]           frames_pending;

    spectrum_binner #(
        .BIT_WIDTH(BW), .IN_WIDTH(IW), .I(NI), .DECIM(ND), .FFT_SIZE(FS)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .fft_re(fft_re),
        .fft_im(fft_im),
        .fft_in_valid(fft_in_valid),
        .fft_in_last(fft_in_last),
        .downstream_ready(downstream_ready),
        .fft_valid(fft_valid),
        .fft_data(fft_data),
        .frame_dropped(frame_dropped),
        .frames_pending(frames_pending)
    );

    // Clock / watchdog
    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int            checks   = 0;
    int            errors   = 0;
    int            run_len  = 0;
    int            exp_run  = NI;
    int            drop_cnt = 0;
    logic [BW-1:0] exp_q[$];

    typedef struct {
        int              len;
        bit              no_last;
        int              re0;
        int              re_step;
        int              im0;
        int              im_step;
        logic [3:0][31:0] exp;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input int len, input bit no_last, input int re0, input int re_step,
                                input int im0, input int im_step, input logic [31:0] e0,
                                input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
        vec_t v;
        v.len = len; v.no_last = no_last;
        v.re0 = re0; v.re_step = re_step; v.im0 = im0; v.im_step = im_step;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every burst word against the expected queue.
    always @(negedge clk_in) begin
        if (fft_valid) begin
            run_len++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected no output at %0t", fft_data, $time);
            end else begin
                check("burst_word", fft_data, exp_q.pop_front());
            end
        end else begin
            check("idle_data_zero", fft_data, 0);
            if (run_len != 0) begin
                check("burst_length", run_len, exp_run);
                run_len = 0;
            end
        end
        if (frame_dropped) drop_cnt++;
    end

    // Driver tasks; all of them start and end one time unit after a rising edge.
    task automatic send_sample(input int re, input int im, input logic last);
        fft_re = IW'(re);
        fft_im = IW'(im);
        fft_in_valid = 1'b1;
        fft_in_last = last;
        @(posedge clk_in); #1;
        fft_in_valid = 1'b0;
        fft_in_last = 1'b0;
    endtask

    task automatic send_frame(input vec_t v, input logic exp_drop);
        for (int s = 0; s < v.len; s++) begin
            fft_re = IW'(v.re0 + v.re_step * s);
            fft_im = IW'(v.im0 + v.im_step * s);
            fft_in_valid = 1'b1;
            fft_in_last = !v.no_last && (s == v.len - 1);
            if (s == 0) begin
                @(negedge clk_in);
                check("dropped_on_first_sample", frame_dropped, exp_drop);
            end
            @(posedge clk_in); #1;
        end
        fft_in_valid = 1'b0;
        fft_in_last = 1'b0;
    endtask

    task automatic push_exp(input vec_t v);
        for (int b = 0; b < NI; b++) exp_q.push_back(v.exp[b]);
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk_in);
            if (exp_q.size() == 0 && !fft_valid) break;
        end
        check(name, exp_q.size(), 0);
        @(posedge clk_in); #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic check_pending(input string name, input int exp);
        @(negedge clk_in);
        check(name, frames_pending, exp);
        @(posedge clk_in); #1;
    endtask

    initial begin
        int first;
        int found;

        vecs[0] = mk(8,  0, 1, 1, 0, 0, 32'd5, 32'd25, 32'd61, 32'd113);
        vecs[1] = mk(3,  0, 2, 1, 0, 0, 32'd13, 32'd16, 32'd0, 32'd0);
        vecs[2] = mk(8,  0, -32768, 0, -32768, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        vecs[3] = mk(8,  0, -1, -1, 1, 0, 32'd7, 32'd27, 32'd63, 32'd115);
        vecs[4] = mk(1,  0, 3, 0, 4, 0, 32'd25, 32'd0, 32'd0, 32'd0);
        vecs[5] = mk(5,  0, 1, 1, 1, 0, 32'd7, 32'd27, 32'd26, 32'd0);
        vecs[6] = mk(12, 0, 1, 1, 0, 0, 32'd5, 32'd25, 32'd61, 32'd113);
        vecs[7] = mk(16, 1, 1, 1, 0, 0, 32'd5, 32'd25, 32'd61, 32'd113);
        vecs[8] = mk(8,  0, 0, 1, 0, 1, 32'd2, 32'd26, 32'd82, 32'd170);

        // Reset
        rst_in = 1'b1;
        fft_re = '0;
        fft_im = '0;
        fft_in_valid = 1'b0;
        fft_in_last = 1'b0;
        downstream_ready = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("reset_fft_valid", fft_valid, 0);
        check("reset_fft_data", fft_data, 0);
        check("reset_frame_dropped", frame_dropped, 0);
        check("reset_frames_pending", frames_pending, 0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // Samples before the first last are ignored; the sync frame is never stored.
        for (int s = 0; s < 3; s++) send_sample(s + 1, 0, 1'b0);
        idle_cycles(3);
        check_pending("presync_pending", 0);
        for (int s = 0; s < 5; s++) send_sample(7, 0, s == 4);
        idle_cycles(3);
        check_pending("sync_frame_pending", 0);

        // Both banks fill with downstream busy; the third frame is dropped.
        send_frame(vecs[0], 1'b0);
        check_pending("pending_after_first", 1);
        send_frame(vecs[3], 1'b0);
        check_pending("pending_after_second", 2);
        drop_cnt = 0;
        send_frame(vecs[2], 1'b1);
        idle_cycles(2);
        check_pending("pending_after_drop", 2);
        check("drop_pulse_count", drop_cnt, 1);

        // Release downstream: bursts of frame 1 then frame 2; first valid 3 cycles after start.
        push_exp(vecs[0]);
        push_exp(vecs[3]);
        downstream_ready = 1'b1;
        first = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            if (fft_valid && first < 0) first = k;
        end
        check("drain_latency", first, 3);
        @(posedge clk_in); #1;
        wait_idle("two_bursts_drained");
        check_pending("pending_after_drain", 0);

        // Vector table with downstream always ready.
        for (int t = 0; t < 9; t++) begin
            push_exp(vecs[t]);
            send_frame(vecs[t], 1'b0);
            wait_idle($sformatf("vec%0d_drained", t));
        end

        // Reset on the second cycle of a burst.
        exp_q.push_back(vecs[0].exp[0]);
        exp_q.push_back(vecs[0].exp[1]);
        exp_run = 2;
        send_frame(vecs[0], 1'b0);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            if (fft_valid) begin
                found = 1;
                break;
            end
        end
        check("burst_seen_before_reset", found, 1);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        @(negedge clk_in);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        check("abort_fft_valid", fft_valid, 0);
        check("abort_fft_data", fft_data, 0);
        check("abort_frames_pending", frames_pending, 0);
        check("abort_words_left", exp_q.size(), 0);
        @(posedge clk_in); #1;
        idle_cycles(3);
        exp_run = NI;

        // After reset the next frame only resyncs; the one after it is emitted.
        send_frame(vecs[5], 1'b0);
        idle_cycles(15);
        check_pending("resync_frame_pending", 0);
        push_exp(vecs[8]);
        send_frame(vecs[8], 1'b0);
        wait_idle("post_reset_frame_drained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
